set_pattern_host: RTL

//  Synthesizable host/initiator for the SET candidate-counting engine. It walks a pattern
//  ROM, drives en/central/radius/mode into SET, and captures the candidate returned on valid.
//  It compares each result against the expected value and reports pass/fail plus error count.

---
 rtl/set_pkg.sv | 15 +
 rtl/set_host_watchdog.sv | 24 ++
 rtl/set_pattern_host.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/set_pkg.sv
// Shared widths, SET mode encodings and host FSM states for the SET pattern host.
package set_pkg;
    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int CAND_W    = 8;

    localparam logic [1:0] MODE_SINGLE    = 2'b00;
    localparam logic [1:0] MODE_UNION     = 2'b01;
    localparam logic [1:0] MODE_DIFF      = 2'b10;
    localparam logic [1:0] MODE_INTERSECT = 2'b11;

    typedef enum logic [3:0] {
        IDLE, FETCH, LOAD, WAIT_IDLE, ISSUE, WAIT_VALID, CHECK, NEXT, DONE
    } host_state_t;
endpackage

// File: rtl/set_host_watchdog.sv
// Cycle watchdog: holds at zero while cleared, counts while enabled, flags the
// TIMEOUT-th enabled cycle.
module set_host_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            cnt <= '0;
        else if (enable && !expire)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/set_pattern_host.sv
// BIST host for the SET core: walks the pattern ROM, issues one request per
// pattern, compares the returned candidate and reports mismatches/watchdog hangs.
module set_pattern_host
    import set_pkg::*;
#(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 4096,
    parameter int MAX_ERR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode_sel,
    output logic [ADDR_W-1:0]    pat_addr,
    input  logic [CENTRAL_W-1:0] pat_central,
    input  logic [RADIUS_W-1:0]  pat_radius,
    input  logic [CAND_W-1:0]    pat_expected,
    output logic                 set_en,
    output logic [CENTRAL_W-1:0] set_central,
    output logic [RADIUS_W-1:0]  set_radius,
    output logic [1:0]           set_mode,
    input  logic                 set_busy,
    input  logic                 set_valid,
    input  logic [CAND_W-1:0]    set_candidate,
    output logic                 mism_pulse,
    output logic [ADDR_W-1:0]    mism_idx,
    output logic [CAND_W-1:0]    mism_got,
    output logic [CAND_W-1:0]    mism_exp,
    output logic [ADDR_W:0]      err_cnt,
    output logic                 done,
    output logic                 pass,
    output logic                 aborted,
    output logic                 timeout
);
    host_state_t state, state_nxt;

    logic [ADDR_W-1:0]    idx;
    logic [CENTRAL_W-1:0] ld_central;
    logic [RADIUS_W-1:0]  ld_radius;
    logic [CAND_W-1:0]    ld_exp;
    logic [CAND_W-1:0]    cand;
    logic [ADDR_W:0]      err_inc;
    logic                 waiting;
    logic                 wd_expire;
    logic                 last_pat;

    assign waiting  = (state == WAIT_IDLE) || (state == WAIT_VALID);
    assign last_pat = (idx == ADDR_W'(NUM_PAT - 1));
    assign err_inc  = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
    assign pat_addr = idx;
    // Gated by rst so the request drops in the same cycle reset is raised.
    assign set_en   = (state == ISSUE) && !rst;
    assign pass     = done && (err_cnt == '0) && !aborted && !timeout;

    set_host_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting),
        .enable (waiting),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = LOAD;
            LOAD:       state_nxt = WAIT_IDLE;
            WAIT_IDLE: begin
                if (!set_busy)      state_nxt = ISSUE;
                else if (wd_expire) state_nxt = DONE;
            end
            ISSUE:      state_nxt = WAIT_VALID;
            WAIT_VALID: begin
                if (set_valid)      state_nxt = CHECK;
                else if (wd_expire) state_nxt = DONE;
            end
            CHECK:      state_nxt = NEXT;
            NEXT:       state_nxt = (aborted || last_pat) ? DONE : FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            ld_central  <= '0;
            ld_radius   <= '0;
            ld_exp      <= '0;
            cand        <= '0;
            set_central <= '0;
            set_radius  <= '0;
            set_mode    <= '0;
            mism_pulse  <= 1'b0;
            mism_idx    <= '0;
            mism_got    <= '0;
            mism_exp    <= '0;
            err_cnt     <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            mism_pulse <= 1'b0;
            if (state_nxt == DONE && state != DONE)
                done <= 1'b1;
            case (state)
                IDLE, DONE: if (start) begin
                    set_mode <= mode_sel;
                    idx      <= '0;
                    err_cnt  <= '0;
                    aborted  <= 1'b0;
                    timeout  <= 1'b0;
                    done     <= 1'b0;
                end
                LOAD: begin
                    ld_central <= pat_central;
                    ld_radius  <= pat_radius;
                    ld_exp     <= pat_expected;
                end
                WAIT_IDLE, WAIT_VALID: begin
                    // SET sees new operands only from the issue cycle onward.
                    if (state_nxt == ISSUE) begin
                        set_central <= ld_central;
                        set_radius  <= ld_radius;
                    end
                    if (state_nxt == CHECK)
                        cand <= set_candidate;
                    if (state_nxt == DONE) begin
                        timeout <= 1'b1;
                        err_cnt <= err_inc;
                    end
                end
                CHECK: if (cand != ld_exp) begin
                    mism_pulse <= 1'b1;
                    mism_idx   <= idx;
                    mism_got   <= cand;
                    mism_exp   <= ld_exp;
                    err_cnt    <= err_inc;
                    if (MAX_ERR != 0 && int'(err_inc) >= MAX_ERR)
                        aborted <= 1'b1;
                end
                NEXT: if (state_nxt == FETCH) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
